// File: rtl/svc_cdc_xfer_tx.sv
// svc_cdc_xfer_tx: source-domain controller for a four-phase req/ack CDC word transfer.
// Optional request timeout is compiled in with `define SVC_CDC_XFER_TIMEOUT_EN.
module svc_cdc_xfer_tx #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             x_req,
    output logic [WIDTH-1:0] x_data,
    input  logic             x_ack_async,
    output logic             busy,
    output logic             err,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ack_meta;
    logic             r_ack_sync;
    logic             w_ack_s;
    logic             r_req;
    logic             w_req_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_accept;
    logic             w_timeout;

    // Only these two flops ever see the raw asynchronous acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= x_ack_async;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack_s = r_ack_sync;

    // A stale high ack left over from an abandoned transfer blocks new words.
    assign s_ready  = rst_n && (r_state == ST_IDLE) && !w_ack_s;
    assign w_accept = s_valid && s_ready;

`ifdef SVC_CDC_XFER_TIMEOUT_EN
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == ST_REQ) && !w_ack_s && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == ST_REQ) && !w_ack_s) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_data_nxt  = s_data;
                end
            end
            ST_REQ: begin
                // A real ack on the timeout edge wins; both paths release the request.
                if (w_ack_s || w_timeout) begin
                    w_state_nxt = ST_REL;
                    w_req_nxt   = 1'b0;
                end
            end
            ST_REL: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign x_req       = r_req;
    assign x_data      = r_data;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: doc/svc_cdc_xfer_tx.md
# svc_cdc_xfer_tx

Source-side controller for a four-phase req/ack clock-domain-crossing transfer of a WIDTH-bit word. It accepts words through a valid/ready port and holds each one stable on `x_data`. It then drives `x_req` to the destination domain and sequences the handshake against the destination's `x_ack_async`, which it brings into `clk` through an internal 2-flop synchronizer. It sits in the source clock domain; the matching receiver lives in the destination domain.

## Interface
- `WIDTH`, 8: transferred word width in bits.
- `TIMEOUT_CYCLES`, 1024: maximum cycles `x_req` stays high awaiting ack. Used only with `SVC_CDC_XFER_TIMEOUT_EN`. Must be ≥ 1.

- `clk`  in  1  source-domain clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  upstream word valid.
- `s_data`  in  WIDTH  upstream word.
- `s_ready`  out  1  controller can accept a word.
- `x_req`  out  1  registered request to the destination domain.
- `x_data`  out  WIDTH  registered word; stable whenever `x_req`=1.
- `x_ack_async`  in  1  raw acknowledge from the destination domain; asynchronous to `clk`.
- `busy`  out  1  handshake in progress (state ≠ IDLE).
- `err`  out  1  one-cycle timeout pulse; tied 0 when the timeout feature is compiled out.

## Operation
- **Ack synchronizer:** two flops on `x_ack_async`, both reset to 0, producing `ack_s`. No other logic touches the raw input.
- **Accept condition:** `s_ready` = `rst_n` && state==IDLE && !`ack_s`.
  - A stale high ack (e.g. after reset mid-transfer) blocks acceptance until it drops.
- **FSM states:** IDLE, REQ, REL.
  - **IDLE:** on `s_valid && s_ready`, latch `s_data` into `x_data`, set `x_req`<=1, go to REQ.
  - **REQ:** on `ack_s`==1, set `x_req`<=0, go to REL.
  - **REL:** on `ack_s`==0, go to IDLE.
- `x_data` changes only on the accept edge; it is held through REQ and REL.
- `busy` = (state != IDLE).
- **Reset values:** state IDLE, `x_req`=0, `x_data`=0, sync flops 0, `err`=0, timeout counter 0.
  - `s_ready`=0 and `busy`=0 while `rst_n` is low.
- **Reset mid-operation:** `x_req` drops on the reset edge, and any in-flight word is abandoned with no retry. The next accept waits for `ack_s`==0.
- `s_valid` while `s_ready`=0 has no effect. Upstream holds the word.

## Timing
- Accept at edge N: `x_req`=1 and `x_data` are valid from edge N.
- `ack_s` follows `x_ack_async` after 2 `clk` edges.
- In REQ, `x_req` falls on the first edge that samples `ack_s`=1.
- REL exits to IDLE on the first edge that samples `ack_s`=0. `s_ready` rises in the following cycle.
- **Loopback** (`x_ack_async` wired to `x_req`):
  - Accept at edge 0.
  - `ack_s`=1 after edge 2; `x_req` falls at edge 3.
  - `ack_s`=0 after edge 5; IDLE at edge 6.
  - Next accept at edge 7, giving 7 cycles per word minimum.
- `s_ready` is combinational from state and `ack_s` only. It never depends on `s_valid`.

## Configuration
- **Macro:** `SVC_CDC_XFER_TIMEOUT_EN`.
- **Defined:**
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`; the counter clears on entering REQ and increments each REQ cycle with `ack_s`=0.
  - On the REQ edge where `ack_s`=0 and count==`TIMEOUT_CYCLES`-1: `x_req`<=0, `err`<=1 for exactly one cycle, go to REL. `x_req` is therefore high exactly `TIMEOUT_CYCLES` cycles.
  - `ack_s`=1 on the same edge wins: normal REL entry, no `err`.
  - The word is dropped.
- **Undefined:** no counter, REQ waits indefinitely, `err` constant 0.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `s_valid`=1 and `x_ack_async`=1 → `x_req`=0, `s_ready`=0, `busy`=0. Release with ack still high → `s_ready` stays 0 until 2 edges after ack drops.
- **Loopback single word:** send `s_data`=8'hA5 → `x_req` high from edge 0 to edge 3, `x_data`=8'hA5 throughout, `s_ready` high again in cycle 7.
- **Loopback back-to-back:** stream 8'h01..8'h04 with `s_valid` held → accepts at edges 0, 7, 14, 21; `x_data` matches in order; no word lost.
- **Delayed ack:** destination acks 10 cycles after `x_req` rises → `x_req` falls 3 edges after ack rises. `x_data` is unchanged until the next accept; `s_valid` pulses during REQ/REL are ignored.
- **Reset mid-REQ:** assert `rst_n`=0 one cycle in REQ → `x_req`=0 next edge, state IDLE, no acceptance while `ack_s`=1.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=4, ack never rises) → `x_req` high exactly 4 cycles, `err`=1 for 1 cycle on the falling edge, `s_ready` high the next cycle. With the macro off → `x_req` held, `err`=0.
